// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int   DATA_BITS = 8;
   localparam int   STOP_BITS = 1;
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
   parameter int CLK_DIV = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic bit_tick_o
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Serial transmitter that pops bytes from a FIFO and sends 8N1 frames back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   state_t     state_q;
   logic [7:0] shift_q;
   logic [2:0] idx_q;
   logic       bit_tick;
   logic       baud_clr;
`ifdef UART_TX_PARITY_EN
   logic       par_q;
`endif

   // Counter is held at zero until the start bit so every bit gets full width.
   assign baud_clr = (state_q == IDLE) || (state_q == LOAD);

   uart_baud_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (baud_clr),
      .bit_tick_o (bit_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  shift_q <= fifo_data;
`ifdef UART_TX_PARITY_EN
                  par_q   <= ^fifo_data;
`endif
                  state_q <= LOAD;
               end
            end
            LOAD: state_q <= START;
            START: begin
               if (bit_tick) begin
                  idx_q   <= '0;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shift_q <= shift_q >> 1;
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) state_q <= STOP;
            end
`endif
            STOP: begin
               if (bit_tick) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      tx = LINE_IDLE;
      case (state_q)
         START:  tx = 1'b0;
         DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
         PARITY: tx = par_q;
`endif
         default: tx = LINE_IDLE;
      endcase
   end

   // The pop is combinational so the byte is captured on the same edge.
   assign fifo_rd_en = (state_q == IDLE) && !fifo_empty && !rst;
   assign busy       = (state_q != IDLE);
   assign tx_done    = (state_q == STOP) && bit_tick;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench for uart_tx_fifo_drain at CLK_DIV=4 and CLK_DIV=2.
module tb_uart_tx_fifo_drain;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       empty4 = 1'b1, empty2 = 1'b1;
   logic [7:0] fdata = 8'h00;
   logic       rd4, rd2, tx4, tx2, busy4, busy2, done4, done2;

   always #5 clk = ~clk;

   uart_tx_fifo_drain #(.CLK_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .fifo_empty(empty4), .fifo_data(fdata),
      .fifo_rd_en(rd4), .tx(tx4), .busy(busy4), .tx_done(done4));

   uart_tx_fifo_drain #(.CLK_DIV(2)) u_dut2 (
      .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_data(fdata),
      .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .tx_done(done2));

   int         n_chk = 0, n_fail = 0;
   logic       sel = 1'b0;
   logic       force_empty = 1'b0;
   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   bit         popped = 1'b0;
   int         pops = 0, dones = 0, nsent = 0;
   bit         in_frame = 1'b0;
   int         off = 0;
   logic [7:0] cur = 8'h00;

   logic m_empty, m_rd, m_tx, m_busy, m_done;
   int   mdiv;
   assign m_empty = sel ? empty2 : empty4;
   assign m_rd    = sel ? rd2 : rd4;
   assign m_tx    = sel ? tx2 : tx4;
   assign m_busy  = sel ? busy2 : busy4;
   assign m_done  = sel ? done2 : done4;
   assign mdiv    = sel ? 2 : 4;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic exp_tx(input logic [7:0] b, input int o, input int div);
      int k;
      if (o == 0) return 1'b1;
      k = (o - 1) / div;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (NB == 11 && k == 9) return ^b;
      return 1'b1;
   endfunction

   // FIFO model: retire the popped byte after the capturing edge, then present the next.
   always @(posedge clk) begin
      logic e;
      #1;
      if (popped) begin
         popped = 1'b0;
         if (fq.size() > 0) void'(fq.pop_front());
      end
      e      = (fq.size() == 0) || force_empty;
      fdata  = (fq.size() > 0) ? fq[0] : 8'h00;
      empty4 = sel ? 1'b1 : e;
      empty2 = sel ? e : 1'b1;
   end

   // Monitor: per-cycle comparison of {tx,busy,tx_done,fifo_rd_en} against the frame model.
   always @(negedge clk) begin
      int flen;
      flen = 1 + NB * mdiv;
      if (m_done) dones++;
      if (rst) begin
         in_frame = 1'b0;
         chk("reset_outputs", {m_tx, m_busy, m_done, m_rd}, 4'b1000);
      end else if (in_frame) begin
         off++;
         chk("frame_cycle", {m_tx, m_busy, m_done, m_rd},
             {exp_tx(cur, off, mdiv), 1'b1, (off == flen - 1), 1'b0});
         if (off == flen - 1) in_frame = 1'b0;
      end else begin
         chk("idle_cycle", {m_tx, m_busy, m_done, m_rd}, {3'b100, !m_empty});
         if (m_rd) begin
            popped = 1'b1;
            pops++;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_pop: got pop expected none at %0t", $time);
            end else begin
               cur      = exp_q.pop_front();
               in_frame = 1'b1;
               off      = -1;
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
      nsent++;
   endtask

   task automatic wait_pop(input int target, input int lim);
      for (int i = 0; i < lim && pops < target; i++) @(negedge clk);
      chk("pop_timeout", (pops >= target), 1);
   endtask

   task automatic wait_idle(input int lim);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (fq.size() == 0 && exp_q.size() == 0 && !in_frame) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_timeout", ok, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int p;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", tx4, 1);
      chk("rst_busy", busy4, 0);
      chk("rst_rd_en", rd4, 0);
      chk("rst_done", done4, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // Single byte, then back-to-back all-zero / all-one frames.
      send(8'hA5);
      wait_idle(200);
      send(8'h00);
      send(8'hFF);
      wait_idle(300);

      // fifo_empty pulses high mid-frame with a second byte waiting.
      p = pops;
      send(8'h3C);
      send(8'hC3);
      wait_pop(p + 1, 50);
      repeat (15) @(posedge clk);
      #1 force_empty = 1'b1;
      repeat (3) @(posedge clk);
      #1 force_empty = 1'b0;
      wait_idle(300);

      // Reset during data bit 3 drops the in-flight byte.
      p = pops;
      send(8'h96);
      wait_pop(p + 1, 50);
      @(posedge clk);
      repeat (18) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_tx", tx4, 1);
      chk("midrst_busy", busy4, 0);
      chk("midrst_rd_en", rd4, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      chk("no_repop", pops, p + 1);
      send(8'h5A);
      wait_idle(200);

      // Minimum divider.
      @(posedge clk);
      #1 sel = 1'b1;
      repeat (2) @(posedge clk);
      send(8'h55);
      wait_idle(200);
`ifdef UART_TX_PARITY_EN
      send(8'h07);
      send(8'h03);
      wait_idle(200);
`endif

      chk("pop_count", pops, nsent);
      chk("done_count", dones, nsent - 1);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
